ex_stage_md: RTL and testbench

Execute stage with operand forwarding, a registered EX/MEM output, and an iterative multiply/divide unit that owns the HI/LO registers. It sits between decode and memory in the 5-stage MIPS pipeline and is parametrised in datapath width. It also generates a stall request back to decode when a HI/LO-dependent instruction reaches a busy multiply/divide unit.

---
 rtl/ex_pkg.sv | 49 ++++
 rtl/alu.sv | 38 +++
 rtl/ex_stage_md_md_unit.sv | 134 +++++++++++++
 rtl/ex_stage_md.sv | 133 +++++++++++++
 tb/tb_ex_stage_md.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, multiply/divide ops,
// forwarding selects and the multiply/divide FSM states.
package ex_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_RF2 = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Ops that occupy the iterative unit for XLEN cycles.
  function automatic logic md_is_arith(md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Shifts take the amount from A and shift B,
// so shamt and variable shifts share one path.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = a_i[SW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_SLL:  y_o = b_i << sh;
      ALU_SRL:  y_o = b_i >> sh;
      ALU_SRA:  y_o = $signed(b_i) >>> sh;
      ALU_LUI:  y_o = b_i << (XLEN/2);
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_md_md_unit.sv
// Iterative multiply/divide unit owning HI/LO. One shift-add or restoring
// subtract step per cycle on operand magnitudes; signs are applied at the end.
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            wr_hi_i,
  input  logic            wr_lo_i,
  output logic            busy_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(XLEN+1);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, lw_q, opnd_q, dvd_q, hi_q, lo_q;
  logic            div_q, neg_q, neg_rem_q, dz_q;

  logic            is_div, sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div = op_i inside {MD_DIV, MD_DIVU};
    sgn    = op_i inside {MD_MULT, MD_DIV};
    sa     = sgn & a_i[XLEN-1];
    sb     = sgn & b_i[XLEN-1];
    mag_a  = sa ? -a_i : a_i;
    mag_b  = sb ? -b_i : b_i;
  end

  // The first step runs on the start edge straight from the fresh operands,
  // so XLEN steps complete on the edge where the counter reaches 1.
  logic [XLEN-1:0] s_acc, s_lo, s_opnd, st_acc, st_lo;
  logic            s_div, ge;
  logic [XLEN:0]   sum, rsh, diff;

  always_comb begin
    s_acc  = start_i ? '0     : acc_q;
    s_lo   = start_i ? mag_a  : lw_q;
    s_opnd = start_i ? mag_b  : opnd_q;
    s_div  = start_i ? is_div : div_q;
    sum    = {1'b0, s_acc} + (s_lo[0] ? {1'b0, s_opnd} : '0);
    rsh    = {s_acc, s_lo[XLEN-1]};
    ge     = rsh >= {1'b0, s_opnd};
    diff   = rsh - {1'b0, s_opnd};
    if (s_div) begin
      st_acc = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
      st_lo  = {s_lo[XLEN-2:0], ge};
    end else begin
      st_acc = sum[XLEN:1];
      st_lo  = {sum[0], s_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod = {st_acc, st_lo};
    if (neg_q) prod = -prod;
    if (!div_q) begin
      fin_hi = prod[2*XLEN-1:XLEN];
      fin_lo = prod[XLEN-1:0];
    end else if (dz_q) begin
      fin_hi = dvd_q;
      fin_lo = '1;
    end else begin
      fin_hi = neg_rem_q ? -st_acc : st_acc;
      fin_lo = neg_q     ? -st_lo  : st_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lw_q      <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q   <= MD_RUN;
            cnt_q     <= CW'(XLEN);
            acc_q     <= st_acc;
            lw_q      <= st_lo;
            opnd_q    <= mag_b;
            dvd_q     <= a_i;
            div_q     <= is_div;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            dz_q      <= (b_i == '0);
          end else begin
            if (wr_hi_i) hi_q <= a_i;
            if (wr_lo_i) lo_q <= a_i;
          end
        end
        MD_RUN: begin
          acc_q <= st_acc;
          lw_q  <= st_lo;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(2)) begin
            state_q <= MD_IDLE;
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MD_RUN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, HI/LO access via the iterative
// multiply/divide unit, and the EX/MEM pipeline register.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc_4,
  input  logic [31:0]     instruction,
  input  logic [4:0]      alu_op,
  input  logic [3:0]      md_op,
  input  logic            use_shamt,
  input  logic            use_imm,
  input  logic            is_jal,
  input  logic            write_rt,
  input  logic [XLEN-1:0] shamt,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_rt_data,
  output logic [4:0]      out_dest,
  output logic            out_zero,
  output logic [XLEN-1:0] out_branch_pc
);

  md_op_e          mop;
  logic [XLEN-1:0] opa, opb, alu_a, alu_b, alu_y, hi, lo;
  logic            md_busy, accept;
  logic            unused_instr;

  assign mop          = md_op_e'(md_op);
  assign unused_instr = ^{instruction[31:21], instruction[10:0]};

  always_comb begin
    case (fwd_sel_e'(fwd_a))
      FWD_MEM: opa = mem_fwd_data;
      FWD_WB:  opa = wb_fwd_data;
      default: opa = rs_data;
    endcase
    case (fwd_sel_e'(fwd_b))
      FWD_MEM: opb = mem_fwd_data;
      FWD_WB:  opb = wb_fwd_data;
      default: opb = rt_data;
    endcase
  end

  assign alu_a = use_shamt ? shamt : opa;
  assign alu_b = use_imm   ? imm   : opb;

  alu #(.XLEN(XLEN)) u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  assign busy   = in_valid & md_busy & (mop != MD_NONE);
  assign accept = in_valid & ~mem_stall & ~busy & ~flush;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & md_is_arith(mop)),
    .op_i    (mop),
    .a_i     (opa),
    .b_i     (opb),
    .wr_hi_i (accept & (mop == MD_MTHI)),
    .wr_lo_i (accept & (mop == MD_MTLO)),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  logic [XLEN-1:0] result_d, result_q, rt_q, bpc_q;
  logic [4:0]      dest_d, dest_q;
  logic            valid_q, zero_q;

  always_comb begin
    result_d = alu_y;
    dest_d   = write_rt ? instruction[20:16] : instruction[15:11];
    if (is_jal) begin
      result_d = pc_4 + XLEN'(4);
      dest_d   = LINK_REG;
    end else if (mop == MD_MFHI) begin
      result_d = hi;
    end else if (mop == MD_MFLO) begin
      result_d = lo;
    end else if (md_is_arith(mop) || mop == MD_MTHI || mop == MD_MTLO) begin
      dest_d = 5'd0;
    end
  end

  // mem_stall freezes everything; otherwise a non-accept cycle inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rt_q     <= '0;
      dest_q   <= '0;
      zero_q   <= 1'b0;
      bpc_q    <= '0;
    end else if (!mem_stall) begin
      valid_q <= accept;
      if (accept) begin
        result_q <= result_d;
        rt_q     <= opb;
        dest_q   <= dest_d;
        zero_q   <= (alu_y == '0);
        bpc_q    <= pc_4 + (imm << 2);
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_rt_data   = rt_q;
  assign out_dest      = dest_q;
  assign out_zero      = zero_q;
  assign out_branch_pc = bpc_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: forwarding, link/branch, HI/LO ops,
// multiply/divide corner cases, stall/flush priority and mid-run reset.
module tb_ex_stage_md;
  import ex_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, use_shamt, use_imm, is_jal, write_rt, mem_stall, flush;
  logic [XLEN-1:0] pc_4, shamt, imm, rs_data, rt_data, mem_fwd_data, wb_fwd_data;
  logic [31:0] instruction;
  logic [4:0]  alu_op;
  logic [3:0]  md_op;
  logic [1:0]  fwd_a, fwd_b;
  logic busy, out_valid, out_zero;
  logic [XLEN-1:0] out_result, out_rt_data, out_branch_pc;
  logic [4:0] out_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_4(pc_4), .instruction(instruction),
    .alu_op(alu_op), .md_op(md_op), .use_shamt(use_shamt), .use_imm(use_imm),
    .is_jal(is_jal), .write_rt(write_rt), .shamt(shamt), .imm(imm),
    .rs_data(rs_data), .rt_data(rt_data), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .mem_stall(mem_stall),
    .flush(flush), .busy(busy), .out_valid(out_valid), .out_result(out_result),
    .out_rt_data(out_rt_data), .out_dest(out_dest), .out_zero(out_zero),
    .out_branch_pc(out_branch_pc)
  );

  function automatic logic [31:0] mk(input logic [4:0] rt, input logic [4:0] rd);
    return {11'b0, rt, rd, 11'b0};
  endfunction

  task automatic clear_in();
    in_valid = 0; pc_4 = 0; instruction = 0; alu_op = ALU_ADD; md_op = MD_NONE;
    use_shamt = 0; use_imm = 0; is_jal = 0; write_rt = 0; shamt = 0; imm = 0;
    rs_data = 0; rt_data = 0; fwd_a = 0; fwd_b = 0; mem_fwd_data = 0; wb_fwd_data = 0;
    mem_stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_in(); rst = 1; in_valid = 1; md_op = MD_MULT;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", out_valid); end
    checks++; if (out_result !== '0 || out_rt_data !== '0 || out_branch_pc !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", out_result, out_rt_data, out_branch_pc); end
    checks++; if (out_dest !== 5'd0 || out_zero !== 1'b0) begin errors++; $display("FAIL reset_dest got %0d/%0d want 0/0", out_dest, out_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
    clear_in(); rst = 0;
    tick();
  endtask

  task automatic test_alu_fwd();
    clear_in(); in_valid = 1; alu_op = ALU_ADD; fwd_a = 2'd1; mem_fwd_data = 5;
    rs_data = 100; rt_data = 7; instruction = mk(5'd3, 5'd10);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd12) begin errors++; $display("FAIL add_fwd_mem got v%0d %h want v1 0000000c", out_valid, out_result); end
    checks++; if (out_dest !== 5'd10 || out_zero !== 1'b0 || out_rt_data !== 32'd7) begin errors++; $display("FAIL add_fwd_dest got %0d z%0d rt%h want 10 z0 7", out_dest, out_zero, out_rt_data); end
    alu_op = ALU_SUB; fwd_a = 2'd0; rs_data = 12; fwd_b = 2'd2; wb_fwd_data = 12; rt_data = 99; write_rt = 1;
    tick();
    checks++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin errors++; $display("FAIL sub_fwd_wb got %h z%0d want 0 z1", out_result, out_zero); end
    checks++; if (out_dest !== 5'd3 || out_rt_data !== 32'd12) begin errors++; $display("FAIL sub_dest_rt got %0d rt%h want 3 0000000c", out_dest, out_rt_data); end
    alu_op = ALU_OR; fwd_a = 2'd3; rs_data = 32'hF0; fwd_b = 2'd0; use_imm = 1; imm = 32'h0F; write_rt = 0;
    tick();
    checks++; if (out_result !== 32'hFF) begin errors++; $display("FAIL or_imm_fwd3 got %h want 000000ff", out_result); end
    alu_op = ALU_SLL; use_imm = 0; use_shamt = 1; shamt = 4; rt_data = 3;
    tick();
    checks++; if (out_result !== 32'h30) begin errors++; $display("FAIL sll_shamt got %h want 00000030", out_result); end
    clear_in();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble got %0d want 0", out_valid); end
  endtask

  task automatic test_jal_branch();
    clear_in(); in_valid = 1; is_jal = 1; pc_4 = 32'h100; instruction = mk(5'd2, 5'd10);
    tick();
    checks++; if (out_dest !== 5'd31 || out_result !== 32'h104) begin errors++; $display("FAIL jal got %0d %h want 31 00000104", out_dest, out_result); end
    is_jal = 0; imm = 32'hFFFF_FFFF;
    tick();
    checks++; if (out_branch_pc !== 32'hFC || out_dest !== 5'd10) begin errors++; $display("FAIL branch_neg got %h d%0d want 000000fc d10", out_branch_pc, out_dest); end
    imm = 32'd3;
    tick();
    checks++; if (out_branch_pc !== 32'h10C) begin errors++; $display("FAIL branch_pos got %h want 0000010c", out_branch_pc); end
    clear_in();
  endtask

  task automatic test_flush();
    clear_in(); in_valid = 1; rs_data = 1; rt_data = 1; instruction = mk(5'd1, 5'd2);
    tick();
    flush = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush got %0d want 0", out_valid); end
    clear_in();
  endtask

  task automatic test_mt();
    clear_in(); in_valid = 1; md_op = MD_MTHI; fwd_a = 2'd2; wb_fwd_data = 32'h1234; instruction = mk(5'd4, 5'd5);
    tick();
    checks++; if (out_dest !== 5'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL mthi_dest got %0d v%0d want 0 v1", out_dest, out_valid); end
    md_op = MD_MTLO; fwd_a = 2'd0; rs_data = 32'h55;
    tick();
    md_op = MD_MFHI;
    tick();
    checks++; if (out_result !== 32'h1234 || out_dest !== 5'd5) begin errors++; $display("FAIL mfhi_after_mthi got %h d%0d want 00001234 d5", out_result, out_dest); end
    md_op = MD_MFLO;
    tick();
    checks++; if (out_result !== 32'h55) begin errors++; $display("FAIL mflo_after_mtlo got %h want 00000055", out_result); end
    clear_in();
  endtask

  task automatic test_mult_mflo();
    int n;
    logic vbad;
    clear_in(); in_valid = 1; md_op = MD_MULT; rs_data = -32'sd3; rt_data = 32'd4; instruction = mk(5'd4, 5'd9);
    tick();
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd0) begin errors++; $display("FAIL mult_retire got v%0d d%0d want v1 d0", out_valid, out_dest); end
    md_op = MD_MFLO; rs_data = 0; rt_data = 0; instruction = mk(5'd0, 5'd8);
    n = 0; vbad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 1 && out_valid) vbad = 1;
      @(posedge clk); #1;
    end
    checks++; if (n != 31) begin errors++; $display("FAIL mult_busy_cycles got %0d want 31", n); end
    checks++; if (vbad !== 1'b0) begin errors++; $display("FAIL stall_bubble got %0d want 0", vbad); end
    tick();
    checks++; if (out_result !== 32'hFFFF_FFF4 || out_dest !== 5'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL mult_lo got %h d%0d v%0d want fffffff4 d8 v1", out_result, out_dest, out_valid); end
    md_op = MD_MFHI;
    tick();
    checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", out_result); end
    clear_in();
  endtask

  task automatic test_div();
    int n;
    logic [3:0]  ops [4];
    logic [31:0] av [4], bv [4], elo [4], ehi [4];
    ops = '{MD_DIV, MD_DIV, MD_DIV, MD_MULTU};
    av  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    bv  = '{32'd0, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    elo = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0000_0001};
    ehi = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      clear_in(); in_valid = 1; md_op = ops[i]; rs_data = av[i]; rt_data = bv[i];
      tick();
      md_op = MD_MFLO; rs_data = 0; rt_data = 0;
      n = 0;
      repeat (100) begin
        @(negedge clk);
        if (!busy) break;
        n++;
        @(posedge clk); #1;
      end
      tick();
      checks++; if (out_result !== elo[i]) begin errors++; $display("FAIL md_lo[%0d] got %h want %h", i, out_result, elo[i]); end
      md_op = MD_MFHI;
      tick();
      checks++; if (out_result !== ehi[i]) begin errors++; $display("FAIL md_hi[%0d] got %h want %h", i, out_result, ehi[i]); end
    end
    clear_in();
  endtask

  task automatic test_stall_flush();
    int n;
    logic frz_bad;
    clear_in(); in_valid = 1; md_op = MD_DIVU; alu_op = ALU_ADD; rs_data = 100; rt_data = 7;
    tick();
    checks++; if (out_result !== 32'd107 || out_valid !== 1'b1) begin errors++; $display("FAIL divu_load got %h v%0d want 0000006b v1", out_result, out_valid); end
    md_op = MD_MFLO; rs_data = 0; rt_data = 0; instruction = mk(5'd0, 5'd6); mem_stall = 1; flush = 1;
    frz_bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy !== 1'b1) frz_bad = 1;
      tick();
      if (out_valid !== 1'b1 || out_result !== 32'd107 || out_dest !== 5'd0) frz_bad = 1;
    end
    checks++; if (frz_bad !== 1'b0) begin errors++; $display("FAIL stall_freeze got v%0d %h d%0d want v1 0000006b d0", out_valid, out_result, out_dest); end
    mem_stall = 0; flush = 0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n != 28) begin errors++; $display("FAIL md_kept_running got %0d busy cycles want 28", n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_after_stall got %0d want 0", out_valid); end
    tick();
    checks++; if (out_result !== 32'd14 || out_dest !== 5'd6) begin errors++; $display("FAIL divu_lo got %h d%0d want 0000000e d6", out_result, out_dest); end
    md_op = MD_MFHI;
    tick();
    checks++; if (out_result !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", out_result); end
    clear_in();
  endtask

  task automatic test_reset_mid_run();
    clear_in(); in_valid = 1; md_op = MD_MULT; alu_op = ALU_ADD; rs_data = 5; rt_data = 6;
    tick();
    checks++; if (out_result !== 32'd11) begin errors++; $display("FAIL pre_reset got %h want 0000000b", out_result); end
    clear_in();
    repeat (5) tick();
    rst = 1; #1;
    checks++; if (out_valid !== 1'b0 || out_result !== '0) begin errors++; $display("FAIL async_reset got v%0d %h want v0 0", out_valid, out_result); end
    tick();
    rst = 0; in_valid = 1; md_op = MD_MFHI; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_reset got %0d want 0", busy); end
    tick();
    checks++; if (out_result !== '0 || out_valid !== 1'b1) begin errors++; $display("FAIL hi_after_reset got %h v%0d want 0 v1", out_result, out_valid); end
    md_op = MD_MFLO;
    tick();
    checks++; if (out_result !== '0) begin errors++; $display("FAIL lo_after_reset got %h want 0", out_result); end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_alu_fwd();
    test_jal_branch();
    test_flush();
    test_mt();
    test_mult_mflo();
    test_div();
    test_stall_flush();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
